// File: rtl/pdm_cic_decim.sv
// rtl/pdm_cic_decim.sv - 3rd-order CIC PDM-to-PCM decimator
// Optional DC-blocking high-pass after the output shift when PDM_DC_BLOCK_EN is defined.
module pdm_cic_decim #(
  parameter int DECIM = 64,
  parameter int OUT_W = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    en,
  input  logic                    pdm_data,
  input  logic                    pdm_valid,
  output logic signed [OUT_W-1:0] pcm_data,
  output logic                    pcm_valid
);

  localparam int LOG_D = $clog2(DECIM);
  localparam int ACC_W = 2 + 3 * LOG_D;
  localparam int EXT_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;
  localparam int SHR   = (ACC_W >= OUT_W) ? (ACC_W - OUT_W) : 0;
  localparam int SHL   = (ACC_W < OUT_W) ? (OUT_W - ACC_W) : 0;

  logic signed [ACC_W-1:0] x_in;
  logic signed [ACC_W-1:0] i1, i2, i3;
  logic signed [ACC_W-1:0] d1, d2, d3;
  logic signed [ACC_W-1:0] c1, c2, c3_diff;
  logic signed [EXT_W-1:0] c3_ext;
  logic signed [OUT_W-1:0] pcm_next;
  logic [LOG_D-1:0]        dcnt;
  logic [1:0]              warm;
  logic                    v0, v1, v2;

  assign x_in     = pdm_data ? ACC_W'(1) : '1;
  assign c3_diff  = c2 - d3;
  assign c3_ext   = EXT_W'(c3_diff);
  assign pcm_next = OUT_W'((c3_ext >>> SHR) <<< SHL);

`ifdef PDM_DC_BLOCK_EN
  localparam int DC_W = OUT_W + 8;
  logic signed [OUT_W-1:0] c3;
  logic                    v3;
  logic signed [DC_W-1:0]  dc_x, dc_x1, dc_y1, dc_y;

  // Input is scaled up by 2^8 so the leak term keeps fractional precision.
  assign dc_x = {c3, 8'b0};
  assign dc_y = dc_x - dc_x1 + dc_y1 - (dc_y1 >>> 8);
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      i1        <= '0;
      i2        <= '0;
      i3        <= '0;
      d1        <= '0;
      d2        <= '0;
      d3        <= '0;
      c1        <= '0;
      c2        <= '0;
      dcnt      <= '0;
      warm      <= '0;
      v0        <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      pcm_data  <= '0;
      pcm_valid <= 1'b0;
`ifdef PDM_DC_BLOCK_EN
      c3        <= '0;
      v3        <= 1'b0;
      dc_x1     <= '0;
      dc_y1     <= '0;
`endif
    end else if (!en) begin
      // Disable wins over a coincident strobe; pcm_data keeps the last sample.
      i1        <= '0;
      i2        <= '0;
      i3        <= '0;
      d1        <= '0;
      d2        <= '0;
      d3        <= '0;
      c1        <= '0;
      c2        <= '0;
      dcnt      <= '0;
      warm      <= '0;
      v0        <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      pcm_valid <= 1'b0;
`ifdef PDM_DC_BLOCK_EN
      c3        <= '0;
      v3        <= 1'b0;
      dc_x1     <= '0;
      dc_y1     <= '0;
`endif
    end else begin
      if (pdm_valid) begin
        i1   <= i1 + x_in;
        i2   <= i2 + i1;
        i3   <= i3 + i2;
        dcnt <= dcnt + LOG_D'(1);
      end
      v0 <= pdm_valid && (dcnt == LOG_D'(DECIM - 1));
      v1 <= v0;
      v2 <= v1;

      if (v0) begin
        c1 <= i3 - d1;
        d1 <= i3;
      end
      if (v1) begin
        c2 <= c1 - d2;
        d2 <= c1;
      end

`ifdef PDM_DC_BLOCK_EN
      v3 <= 1'b0;
      if (v2) begin
        d3 <= c2;
        if (warm == 2'd3) begin
          v3 <= 1'b1;
          c3 <= pcm_next;
        end else begin
          warm <= warm + 2'd1;
        end
      end
      pcm_valid <= v3;
      if (v3) begin
        dc_x1    <= dc_x;
        dc_y1    <= dc_y;
        pcm_data <= dc_y[DC_W-1 -: OUT_W];
      end
`else
      pcm_valid <= 1'b0;
      if (v2) begin
        d3 <= c2;
        // The first three comb outputs carry start-up transients.
        if (warm == 2'd3) begin
          pcm_valid <= 1'b1;
          pcm_data  <= pcm_next;
        end else begin
          warm <= warm + 2'd1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_pdm_cic_decim.sv
// tb/tb_pdm_cic_decim.sv - directed self-checking bench for pdm_cic_decim
module tb_pdm_cic_decim;

`ifdef PDM_DC_BLOCK_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic               clk = 1'b0;
  logic               resetn = 1'b0;
  logic               en = 1'b0;
  logic               pdm_data = 1'b0;
  logic               pdm_valid = 1'b0;
  logic signed [15:0] pcm_data;
  logic               pcm_valid;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;
  int acc_n = 0;
  int evt_edge = 0;
  int pulses = 0;
  int exp_val = 0;
  int p0 = 0;
  bit chk_val = 1'b0;

  pdm_cic_decim #(.DECIM(64), .OUT_W(16)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .en        (en),
    .pdm_data  (pdm_data),
    .pdm_valid (pdm_valid),
    .pcm_data  (pcm_data),
    .pcm_valid (pcm_valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference bookkeeping: accepted strobes and the edge completing each window.
  always @(posedge clk) begin
    edge_n++;
    if (!resetn || !en) acc_n = 0;
    else if (pdm_valid) begin
      acc_n++;
      if (acc_n % 64 == 0) evt_edge = edge_n;
    end
  end

  always @(negedge clk) begin
    if (pcm_valid) begin
      pulses++;
      check_eq("latency", edge_n - evt_edge, LAT);
`ifndef PDM_DC_BLOCK_EN
      if (chk_val) check_eq("pcm_value", int'(pcm_data), exp_val);
`endif
    end
  end

  task automatic strobe(input logic b);
    @(negedge clk);
    pdm_data  = b;
    pdm_valid = 1'b1;
    @(negedge clk);
    pdm_valid = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // mode 0: zeros, 1: ones, 2: alternating starting with 1
  task automatic run(input int n, input int mode);
    for (int i = 0; i < n; i++)
      strobe((mode == 2) ? ((i % 2) == 0) : (mode == 1));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_valid", int'(pcm_valid), 0);
    check_eq("rst_data", int'(pcm_data), 0);
    @(negedge clk);
    resetn = 1'b1;
    en     = 1'b1;

    chk_val = 1'b1;
    exp_val = 16384;
    p0 = pulses;
    run(640, 1);
    check_eq("ones_pulses", pulses - p0, 7);

    // Reset lands while a completed window is still in the comb pipeline.
    run(191, 1);
    @(negedge clk);
    pdm_data  = 1'b1;
    pdm_valid = 1'b1;
    @(negedge clk);
    pdm_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check_eq("midrst_data", int'(pcm_data), 0);
    check_eq("midrst_valid", int'(pcm_valid), 0);
    p0 = pulses;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    run(255, 1);
    check_eq("midrst_warmup", pulses - p0, 0);
    run(1, 1);
    check_eq("midrst_first", pulses - p0, 1);

    pulse_reset();
    exp_val = -16384;
    p0 = pulses;
    run(640, 0);
    check_eq("zeros_pulses", pulses - p0, 7);

    pulse_reset();
    exp_val = 0;
    p0 = pulses;
    run(640, 2);
    check_eq("alt_pulses", pulses - p0, 7);

    // Enable drop after 100 ones, restored after 150.
    chk_val = 1'b0;
    run(100, 1);
    en = 1'b0;
    p0 = pulses;
    run(50, 1);
    check_eq("en_low_pulses", pulses - p0, 0);
    check_eq("en_low_valid", int'(pcm_valid), 0);
    en = 1'b1;
    chk_val = 1'b1;
    exp_val = 16384;
    p0 = pulses;
    run(255, 1);
    check_eq("en_warmup", pulses - p0, 0);
    run(1, 1);
    check_eq("en_first", pulses - p0, 1);

    repeat (10) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
